clint_dbus_slave: RTL and testbench
===================================

# clint_dbus_slave

Memory-mapped core-local interruptor (CLINT) that answers data-bus requests issued by the core's load/store unit and drives the timer/software interrupt inputs of the CSR unit. It sits on the data-bus fabric as a responder and holds the 64-bit `mtime` counter, the 64-bit `mtimecmp` compare register and the `msip` bit. A two-state FSM implements a request/acknowledge handshake, and a prescaler advances `mtime`.

## Interface
- `PRESCALE`, 10: clk cycles per `mtime` increment; legal range 1..1023.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `dbus_req_i`  in  1  request valid; initiator holds it and all request fields stable until `dbus_ack_o`.
- `dbus_w_en_i`  in  1  1 = write, 0 = read.
- `dbus_addr_i`  in  16  byte offset within the CLINT window; bits [1:0] are ignored.
- `dbus_wdata_i`  in  32  write data.
- `dbus_sel_byte_i`  in  4  byte enables for writes; ignored on reads.
- `dbus_ack_o`  out  1  one-cycle response pulse.
- `dbus_rdata_o`  out  32  read data; valid while `dbus_ack_o`=1, 0 otherwise.
- `timer_irq_o`  out  1  machine timer interrupt to CSR.
- `soft_irq_o`  out  1  machine software interrupt to CSR (= `msip`).
- `mtime_o`  out  64  current `mtime`, for the CSR `time` shadow.

## Operation
- Register map, word-aligned:
  - 0x0000: `msip`. Bit 0 is R/W; bits 31:1 read 0.
  - 0x4000 / 0x4004: `mtimecmp` low / high.
  - 0xBFF8 / 0xBFFC: `mtime` low / high.
  - Any other offset reads 0. Writes to it are dropped, but the request is still acked.
- Writes are byte-granular per `dbus_sel_byte_i`. Bytes with sel=0 keep their value.
- FSM states:
  - IDLE, with `dbus_ack_o`=0. If `dbus_req_i`=1: perform the write at this edge (if `dbus_w_en_i`), or capture the read data from register values before the edge. Then go to ACK.
  - ACK, with `dbus_ack_o`=1 and `dbus_rdata_o` driven. Always return to IDLE on the next edge.
- The initiator deasserts `dbus_req_i` in the cycle after ack. `dbus_req_i` is not sampled in ACK, so there is no double accept.
- Prescaler:
  - Counter `pcnt` counts 0..PRESCALE-1 and wraps to 0.
  - On the wrap edge, `mtime` increments by 1.
  - With PRESCALE=1, `mtime` increments every cycle.
- `mtime` wraps 0xFFFF_FFFF_FFFF_FFFF -> 0. There is no carry-out or flag.
- Same-edge write to `mtime` and increment:
  - The bus-written bytes take the written value; the increment is discarded for that edge.
  - Unwritten bytes keep their pre-edge value (no partial increment).
- A write to `mtime` does not reset `pcnt`.
- `timer_irq_o` is registered: each edge it samples (`mtime` >= `mtimecmp`), an unsigned 64-bit compare of the post-edge register values.
- `soft_irq_o` = `msip` register bit, direct from the flop.

## Timing
- Reset values:
  - State IDLE, `dbus_ack_o`=0, `dbus_rdata_o`=0.
  - `mtime`=0, `pcnt`=0.
  - `mtimecmp`=0xFFFF_FFFF_FFFF_FFFF, so no interrupt at reset.
  - `msip`=0, `soft_irq_o`=0, `timer_irq_o`=0.
- Read/write latency: request accepted in cycle N (IDLE, req=1); `dbus_ack_o`=1 in cycle N+1 only. Back-to-back requests are possible every 2 cycles.
- Read data reflects register contents at the end of cycle N. An `mtime` increment at that same edge is not visible.
- A written register holds its new value from cycle N+1.
- `timer_irq_o` rises or falls one cycle after the register condition changes. Raising `mtimecmp` above `mtime` clears it one cycle after the write takes effect.
- `soft_irq_o` changes in cycle N+1 after an `msip` write.
- 64-bit values are not read atomically. Software reads hi/lo/hi; the block provides no latching.
- Reset asserted mid-transaction forces IDLE and `dbus_ack_o`=0 immediately (asynchronously). The pending request is lost, and the initiator must reissue it.

## Test plan
- Reset release with PRESCALE=10, no bus traffic:
  - `mtime_o` = 0 for 10 cycles, then 1 at cycle 10 and 5 at cycle 50.
  - `timer_irq_o` stays 0.
- Write 0x0000_0001 to 0x0000 with sel=0xF:
  - ack exactly one cycle after req.
  - `soft_irq_o`=1 on the ack cycle.
  - Reading 0x0000 returns 0x0000_0001.
- Write `mtimecmp` high=0, low=20 with PRESCALE=1:
  - `timer_irq_o` rises the cycle after `mtime` reaches 20.
  - Writing low=0xFFFF_FFFF, high=0xFFFF_FFFF deasserts it one cycle after that write lands.
- Write 0xAB to 0xBFF8 with sel=0x1 while an increment lands on the same edge, `mtime`=0x1FF prior:
  - `mtime` = 0x1AB afterwards; the increment is discarded.
- Set `mtime` = 0xFFFF_FFFF_FFFF_FFFE with PRESCALE=1:
  - Reads go ...FFFF then 0x0 two cycles later; high word reads 0 after the wrap.
- Bus and reset corner cases:
  - Read from unmapped offset 0x1234 returns 0 with ack.
  - A write there changes no register.
  - Asserting `rst` while in ACK drops `dbus_ack_o` in the same cycle.

Source files
------------

// File: rtl/clint_dbus_slave.sv
// Core-local interruptor on the data bus: mtime/mtimecmp/msip registers behind
// a two-state request/acknowledge responder, with a prescaled mtime counter.
module clint_dbus_slave #(
   parameter int unsigned PRESCALE = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dbus_req_i,
   input  logic        dbus_w_en_i,
   input  logic [15:0] dbus_addr_i,
   input  logic [31:0] dbus_wdata_i,
   input  logic [3:0]  dbus_sel_byte_i,
   output logic        dbus_ack_o,
   output logic [31:0] dbus_rdata_o,
   output logic        timer_irq_o,
   output logic        soft_irq_o,
   output logic [63:0] mtime_o
);

   localparam int unsigned PCNT_W = 10;
   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);

   localparam logic [13:0] W_MSIP    = 14'h0000;
   localparam logic [13:0] W_CMP_LO  = 14'h1000;
   localparam logic [13:0] W_CMP_HI  = 14'h1001;
   localparam logic [13:0] W_TIME_LO = 14'h2FFE;
   localparam logic [13:0] W_TIME_HI = 14'h2FFF;

   typedef enum logic {S_IDLE, S_ACK} state_t;

   state_t            state_q, state_d;
   logic              ack_q, ack_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [PCNT_W-1:0] pcnt_q, pcnt_d;
   logic [63:0]       mtime_q, mtime_d;
   logic [63:0]       mtimecmp_q, mtimecmp_d;
   logic              msip_q, msip_d;
   logic              timer_irq_q, timer_irq_d;

   logic [13:0] word;
   logic        accept;
   logic        wr;
   logic        pcnt_wrap;
   logic [31:0] rd_mux;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^dbus_addr_i[1:0];

   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[b*8 +: 8] = be[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
      end
      return res;
   endfunction

   always_comb begin
      word      = dbus_addr_i[15:2];
      accept    = (state_q == S_IDLE) && dbus_req_i;
      wr        = accept && dbus_w_en_i;
      pcnt_wrap = (pcnt_q == PCNT_LAST);

      pcnt_d     = pcnt_wrap ? '0 : pcnt_q + 1'b1;
      mtime_d    = mtime_q + {63'b0, pcnt_wrap};
      mtimecmp_d = mtimecmp_q;
      msip_d     = msip_q;

      // Read data is taken from pre-edge register values.
      case (word)
         W_MSIP:    rd_mux = {31'b0, msip_q};
         W_CMP_LO:  rd_mux = mtimecmp_q[31:0];
         W_CMP_HI:  rd_mux = mtimecmp_q[63:32];
         W_TIME_LO: rd_mux = mtime_q[31:0];
         W_TIME_HI: rd_mux = mtime_q[63:32];
         default:   rd_mux = 32'b0;
      endcase

      // A bus write to mtime overrides the increment; untouched bytes keep
      // their pre-edge value rather than a partially incremented one.
      if (wr) begin
         case (word)
            W_MSIP:    if (dbus_sel_byte_i[0]) msip_d = dbus_wdata_i[0];
            W_CMP_LO:  mtimecmp_d[31:0]  = byte_merge(mtimecmp_q[31:0], dbus_wdata_i, dbus_sel_byte_i);
            W_CMP_HI:  mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], dbus_wdata_i, dbus_sel_byte_i);
            W_TIME_LO: mtime_d = {mtime_q[63:32], byte_merge(mtime_q[31:0], dbus_wdata_i, dbus_sel_byte_i)};
            W_TIME_HI: mtime_d = {byte_merge(mtime_q[63:32], dbus_wdata_i, dbus_sel_byte_i), mtime_q[31:0]};
            default:   ;
         endcase
      end

      state_d = state_q;
      ack_d   = 1'b0;
      rdata_d = 32'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_ACK;
               ack_d   = 1'b1;
               if (!dbus_w_en_i) rdata_d = rd_mux;
            end
         end
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      timer_irq_d = (mtime_q >= mtimecmp_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ack_q       <= 1'b0;
         rdata_q     <= 32'b0;
         pcnt_q      <= '0;
         mtime_q     <= 64'b0;
         mtimecmp_q  <= {64{1'b1}};
         msip_q      <= 1'b0;
         timer_irq_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ack_q       <= ack_d;
         rdata_q     <= rdata_d;
         pcnt_q      <= pcnt_d;
         mtime_q     <= mtime_d;
         mtimecmp_q  <= mtimecmp_d;
         msip_q      <= msip_d;
         timer_irq_q <= timer_irq_d;
      end
   end

   assign dbus_ack_o   = ack_q;
   assign dbus_rdata_o = rdata_q;
   assign timer_irq_o  = timer_irq_q;
   assign soft_irq_o   = msip_q;
   assign mtime_o      = mtime_q;

endmodule

// File: tb/tb_clint_dbus_slave.sv
// Directed bench for clint_dbus_slave: one instance with PRESCALE=10 and one
// with PRESCALE=1 share the bus stimulus.
module tb_clint_dbus_slave;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        w_en = 1'b0;
   logic [15:0] addr = 16'h0;
   logic [31:0] wdata = 32'h0;
   logic [3:0]  sel = 4'h0;

   logic        ack10, ack1;
   logic [31:0] rdata10, rdata1;
   logic        tirq10, tirq1, sirq10, sirq1;
   logic [63:0] mtime10, mtime1;

   int pass_cnt = 0;
   int check_cnt = 0;

   always #5 clk = ~clk;

   clint_dbus_slave #(.PRESCALE(10)) u_dut10 (
      .clk(clk), .rst(rst), .dbus_req_i(req), .dbus_w_en_i(w_en),
      .dbus_addr_i(addr), .dbus_wdata_i(wdata), .dbus_sel_byte_i(sel),
      .dbus_ack_o(ack10), .dbus_rdata_o(rdata10), .timer_irq_o(tirq10),
      .soft_irq_o(sirq10), .mtime_o(mtime10));

   clint_dbus_slave #(.PRESCALE(1)) u_dut1 (
      .clk(clk), .rst(rst), .dbus_req_i(req), .dbus_w_en_i(w_en),
      .dbus_addr_i(addr), .dbus_wdata_i(wdata), .dbus_sel_byte_i(sel),
      .dbus_ack_o(ack1), .dbus_rdata_o(rdata1), .timer_irq_o(tirq1),
      .soft_irq_o(sirq1), .mtime_o(mtime1));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Raise a request; returns 1ns into the ack cycle with req still held.
   task automatic bus_start(input logic w, input logic [15:0] a,
                            input logic [31:0] d, input logic [3:0] s);
      req = 1'b1; w_en = w; addr = a; wdata = d; sel = s;
      @(posedge clk);
      #1;
   endtask

   task automatic bus_end();
      @(posedge clk);
      #1;
      req = 1'b0; w_en = 1'b0; sel = 4'h0;
   endtask

   task automatic test_reset();
      logic irq_seen;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_cnt++; if (ack1 !== 1'b0) $display("FAIL rst_ack got %0b want 0", ack1); else pass_cnt++;
      check_cnt++; if (rdata1 !== 32'h0) $display("FAIL rst_rdata got %h want 0", rdata1); else pass_cnt++;
      check_cnt++; if (mtime10 !== 64'h0) $display("FAIL rst_mtime got %h want 0", mtime10); else pass_cnt++;
      check_cnt++; if (tirq10 !== 1'b0) $display("FAIL rst_tirq got %0b want 0", tirq10); else pass_cnt++;
      check_cnt++; if (sirq10 !== 1'b0) $display("FAIL rst_sirq got %0b want 0", sirq10); else pass_cnt++;
      rst = 1'b0;
      irq_seen = 1'b0;
      for (int k = 1; k <= 50; k++) begin
         step();
         if (tirq10 === 1'b1 || tirq1 === 1'b1) irq_seen = 1'b1;
         if (k == 9) begin
            check_cnt++; if (mtime10 !== 64'd0) $display("FAIL presc_c9 got %0d want 0", mtime10); else pass_cnt++;
         end
         if (k == 10) begin
            check_cnt++; if (mtime10 !== 64'd1) $display("FAIL presc_c10 got %0d want 1", mtime10); else pass_cnt++;
         end
         if (k == 50) begin
            check_cnt++; if (mtime10 !== 64'd5) $display("FAIL presc_c50 got %0d want 5", mtime10); else pass_cnt++;
            check_cnt++; if (mtime1 !== 64'd50) $display("FAIL presc1_c50 got %0d want 50", mtime1); else pass_cnt++;
         end
      end
      check_cnt++; if (irq_seen !== 1'b0) $display("FAIL rst_tirq_quiet got %0b want 0", irq_seen); else pass_cnt++;
   endtask

   task automatic test_msip();
      bus_start(1'b1, 16'h0000, 32'h0000_0001, 4'hF);
      check_cnt++; if (ack1 !== 1'b1) $display("FAIL msip_ack got %0b want 1", ack1); else pass_cnt++;
      check_cnt++; if (ack10 !== 1'b1) $display("FAIL msip_ack10 got %0b want 1", ack10); else pass_cnt++;
      check_cnt++; if (sirq1 !== 1'b1) $display("FAIL msip_sirq got %0b want 1", sirq1); else pass_cnt++;
      bus_end();
      check_cnt++; if (ack1 !== 1'b0) $display("FAIL msip_single_ack got %0b want 0", ack1); else pass_cnt++;
      bus_start(1'b1, 16'h0000, 32'h0000_0000, 4'hE);
      bus_end();
      check_cnt++; if (sirq1 !== 1'b1) $display("FAIL msip_bytesel got %0b want 1", sirq1); else pass_cnt++;
      bus_start(1'b0, 16'h0000, 32'h0, 4'h0);
      check_cnt++; if (rdata1 !== 32'h0000_0001) $display("FAIL msip_read got %h want 00000001", rdata1); else pass_cnt++;
      bus_end();
      check_cnt++; if (rdata1 !== 32'h0) $display("FAIL rdata_idle got %h want 0", rdata1); else pass_cnt++;
   endtask

   task automatic test_timer();
      int n;
      bus_start(1'b1, 16'h4000, 32'd20, 4'hF);
      bus_end();
      bus_start(1'b1, 16'hBFF8, 32'd0, 4'hF);
      check_cnt++; if (mtime1 !== 64'd0) $display("FAIL time_wr got %0d want 0", mtime1); else pass_cnt++;
      bus_end();
      bus_start(1'b1, 16'h4004, 32'd0, 4'hF);
      bus_end();
      check_cnt++; if (tirq1 !== 1'b0) $display("FAIL tirq_below got %0b want 0", tirq1); else pass_cnt++;
      n = 0;
      while (mtime1 !== 64'd20 && n < 40) begin
         step();
         n++;
      end
      check_cnt++; if (mtime1 !== 64'd20) $display("FAIL tirq_wait got %0d want 20", mtime1); else pass_cnt++;
      check_cnt++; if (tirq1 !== 1'b0) $display("FAIL tirq_at20 got %0b want 0", tirq1); else pass_cnt++;
      step();
      check_cnt++; if (tirq1 !== 1'b1) $display("FAIL tirq_rise got %0b want 1", tirq1); else pass_cnt++;
      bus_start(1'b1, 16'h4000, 32'hFFFF_FFFF, 4'hF);
      check_cnt++; if (tirq1 !== 1'b1) $display("FAIL tirq_hold got %0b want 1", tirq1); else pass_cnt++;
      bus_end();
      check_cnt++; if (tirq1 !== 1'b0) $display("FAIL tirq_fall got %0b want 0", tirq1); else pass_cnt++;
      bus_start(1'b1, 16'h4004, 32'hFFFF_FFFF, 4'hF);
      bus_end();
      check_cnt++; if (tirq1 !== 1'b0) $display("FAIL tirq_off got %0b want 0", tirq1); else pass_cnt++;
   endtask

   task automatic test_back_to_back_collision();
      bus_start(1'b1, 16'hBFF8, 32'h0000_01FE, 4'hF);
      bus_end();
      bus_start(1'b1, 16'hBFF8, 32'h0000_00AB, 4'h1);
      check_cnt++; if (mtime1 !== 64'h1AB) $display("FAIL collide1 got %h want 1ab", mtime1); else pass_cnt++;
      check_cnt++; if (mtime10 !== 64'h1AB) $display("FAIL collide10 got %h want 1ab", mtime10); else pass_cnt++;
      bus_end();
      check_cnt++; if (mtime1 !== 64'h1AC) $display("FAIL collide_next got %h want 1ac", mtime1); else pass_cnt++;
   endtask

   task automatic test_wrap();
      bus_start(1'b1, 16'hBFFC, 32'hFFFF_FFFF, 4'hF);
      bus_end();
      bus_start(1'b1, 16'hBFF8, 32'hFFFF_FFFE, 4'hF);
      bus_end();
      check_cnt++; if (mtime1 !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL wrap_max got %h want ffffffffffffffff", mtime1); else pass_cnt++;
      bus_start(1'b0, 16'hBFF8, 32'h0, 4'h0);
      check_cnt++; if (rdata1 !== 32'hFFFF_FFFF) $display("FAIL wrap_rd_lo got %h want ffffffff", rdata1); else pass_cnt++;
      check_cnt++; if (mtime1 !== 64'h0) $display("FAIL wrap_zero got %h want 0", mtime1); else pass_cnt++;
      bus_end();
      bus_start(1'b0, 16'hBFFC, 32'h0, 4'h0);
      check_cnt++; if (rdata1 !== 32'h0) $display("FAIL wrap_rd_hi got %h want 0", rdata1); else pass_cnt++;
      bus_end();
   endtask

   task automatic test_unmapped();
      bus_start(1'b0, 16'h1234, 32'h0, 4'h0);
      check_cnt++; if (ack1 !== 1'b1) $display("FAIL unmap_rd_ack got %0b want 1", ack1); else pass_cnt++;
      check_cnt++; if (rdata1 !== 32'h0) $display("FAIL unmap_rd got %h want 0", rdata1); else pass_cnt++;
      bus_end();
      bus_start(1'b1, 16'h1234, 32'hDEAD_BEEF, 4'hF);
      check_cnt++; if (ack1 !== 1'b1) $display("FAIL unmap_wr_ack got %0b want 1", ack1); else pass_cnt++;
      bus_end();
      bus_start(1'b0, 16'h4000, 32'h0, 4'h0);
      check_cnt++; if (rdata1 !== 32'hFFFF_FFFF) $display("FAIL unmap_cmplo got %h want ffffffff", rdata1); else pass_cnt++;
      bus_end();
      bus_start(1'b0, 16'h4004, 32'h0, 4'h0);
      check_cnt++; if (rdata1 !== 32'hFFFF_FFFF) $display("FAIL unmap_cmphi got %h want ffffffff", rdata1); else pass_cnt++;
      bus_end();
      bus_start(1'b0, 16'h0000, 32'h0, 4'h0);
      check_cnt++; if (rdata1 !== 32'h1) $display("FAIL unmap_msip got %h want 1", rdata1); else pass_cnt++;
      bus_end();
      bus_start(1'b0, 16'hBFFC, 32'h0, 4'h0);
      check_cnt++; if (rdata1 !== 32'h0) $display("FAIL unmap_timehi got %h want 0", rdata1); else pass_cnt++;
      bus_end();
   endtask

   task automatic test_reset_in_ack();
      bus_start(1'b0, 16'h0000, 32'h0, 4'h0);
      check_cnt++; if (ack1 !== 1'b1) $display("FAIL rack_pre got %0b want 1", ack1); else pass_cnt++;
      #1 rst = 1'b1;
      #1;
      check_cnt++; if (ack1 !== 1'b0) $display("FAIL rack_drop got %0b want 0", ack1); else pass_cnt++;
      check_cnt++; if (rdata1 !== 32'h0) $display("FAIL rack_rdata got %h want 0", rdata1); else pass_cnt++;
      check_cnt++; if (mtime1 !== 64'h0) $display("FAIL rack_mtime got %h want 0", mtime1); else pass_cnt++;
      @(posedge clk);
      #1;
      req = 1'b0;
      rst = 1'b0;
      step();
      check_cnt++; if (ack1 !== 1'b0) $display("FAIL rack_after got %0b want 0", ack1); else pass_cnt++;
      check_cnt++; if (sirq1 !== 1'b0) $display("FAIL rack_sirq got %0b want 0", sirq1); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_msip();
      test_timer();
      test_back_to_back_collision();
      test_wrap();
      test_unmapped();
      test_reset_in_ack();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
